cache_mem_arbiter: RTL

- Shares one single-word memory port between the icache and dcache miss/writeback engines.
- Each grant covers a whole cache-block burst of BLOCK_WORDS beats, so the two requesters never interleave.
- Round-robin arbitration applies on contention; an abort input terminates a burst cleanly at a beat boundary.
- Sits between the separate icache/dcache memory-side ports and the bus controller.

---
 rtl/cache_mem_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/cache_mem_arbiter.sv
// Shares one single-word memory port between icache and dcache block bursts.
// Round-robin on contention; abort ends the burst at the next beat boundary.
module cache_mem_arbiter #(
   parameter int unsigned BLOCK_WORDS  = 4,
   parameter bit          DCACHE_FIRST = 1'b1
) (
   input  logic                           CLK,
   input  logic                           RST,
   input  logic                           abort,
   input  logic                           i_req,
   input  logic [31:0]                    i_addr,
   output logic [31:0]                    i_rdata,
   output logic                           i_beat_ack,
   output logic                           i_done,
   output logic                           i_err,
   input  logic                           d_req,
   input  logic                           d_wen,
   input  logic [31:0]                    d_addr,
   input  logic [31:0]                    d_wdata,
   output logic [$clog2(BLOCK_WORDS)-1:0] d_beat_idx,
   output logic [31:0]                    d_rdata,
   output logic                           d_beat_ack,
   output logic                           d_done,
   output logic                           d_err,
   output logic                           m_ren,
   output logic                           m_wen,
   output logic [31:0]                    m_addr,
   output logic [31:0]                    m_wdata,
   input  logic [31:0]                    m_rdata,
   input  logic                           m_busy
);

   localparam int unsigned BeatW = $clog2(BLOCK_WORDS);
   localparam int unsigned BaseW = 32 - BeatW - 2;
   localparam logic [BeatW-1:0] LastBeat = BeatW'(BLOCK_WORDS - 1);

   localparam logic [0:0] StIdle  = 1'b0;
   localparam logic [0:0] StBurst = 1'b1;

   // Owner / last-grant encoding: 1 = dcache, 0 = icache.
   logic [0:0]       state_q, state_d;
   logic             owner_q, owner_d;
   logic             wen_q, wen_d;
   logic [BaseW-1:0] base_q, base_d;
   logic [BeatW-1:0] beat_q, beat_d;
   logic             abort_pend_q, abort_pend_d;
   logic             last_grant_q, last_grant_d;

   logic in_burst, beat_done, term, term_err;
   logic grant_valid, grant_dcache;

   assign in_burst  = (state_q == StBurst);
   assign beat_done = in_burst & ~m_busy;
   assign term_err  = abort | abort_pend_q;
   assign term      = beat_done & ((beat_q == LastBeat) | term_err);

   assign grant_valid  = (state_q == StIdle) & ~abort & (i_req | d_req);
   assign grant_dcache = (i_req & d_req) ? ~last_grant_q : d_req;

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      wen_d        = wen_q;
      base_d       = base_q;
      beat_d       = beat_q;
      abort_pend_d = abort_pend_q;
      last_grant_d = last_grant_q;
      unique case (state_q)
         StIdle: begin
            if (grant_valid) begin
               state_d      = StBurst;
               owner_d      = grant_dcache;
               wen_d        = grant_dcache & d_wen;
               base_d       = grant_dcache ? d_addr[31:BeatW+2] : i_addr[31:BeatW+2];
               beat_d       = '0;
               abort_pend_d = 1'b0;
            end
         end
         default: begin
            if (abort) abort_pend_d = 1'b1;
            if (term) begin
               // An aborted burst still counts as a turn so the other side is not starved.
               state_d      = StIdle;
               beat_d       = '0;
               abort_pend_d = 1'b0;
               last_grant_d = owner_q;
            end else if (beat_done) begin
               beat_d = beat_q + 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= StIdle;
         owner_q      <= 1'b0;
         wen_q        <= 1'b0;
         base_q       <= '0;
         beat_q       <= '0;
         abort_pend_q <= 1'b0;
         last_grant_q <= ~DCACHE_FIRST;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         wen_q        <= wen_d;
         base_q       <= base_d;
         beat_q       <= beat_d;
         abort_pend_q <= abort_pend_d;
         last_grant_q <= last_grant_d;
      end
   end

   always_comb begin
      m_ren      = in_burst & ~wen_q;
      m_wen      = in_burst & wen_q;
      m_addr     = in_burst ? {base_q, beat_q, 2'b00} : 32'h0;
      m_wdata    = (in_burst & wen_q & owner_q) ? d_wdata : 32'h0;
      d_beat_idx = beat_q;

      i_beat_ack = beat_done & ~owner_q;
      i_done     = term & ~owner_q;
      i_err      = term & term_err & ~owner_q;
      i_rdata    = i_beat_ack ? m_rdata : 32'h0;

      d_beat_ack = beat_done & owner_q;
      d_done     = term & owner_q;
      d_err      = term & term_err & owner_q;
      d_rdata    = d_beat_ack ? m_rdata : 32'h0;
   end

endmodule
